// File: rtl/mul_sequencer.sv
// Sequential shift-and-add unsigned multiplier: one partial product per BUSY cycle.
// Optional build macro MUL_EARLY_EXIT_EN ends BUSY as soon as the remaining multiplier is zero.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [2:0]           ALUCtrl_i,
  input  logic                 flush_i,
  input  logic [WIDTH-1:0]     src1_i,
  input  logic [WIDTH-1:0]     src2_i,
  output logic                 stall_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] ALU_MULT = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   prod_q;
  logic                 busy_q, done_q;
  logic                 accept;
  logic                 last_iter;
  logic                 finish;

  assign accept = start_i && (ALUCtrl_i == ALU_MULT) && !flush_i;

  assign acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mcand_d  = mcand_q << 1;
  assign mplier_d = mplier_q >> 1;
  assign cnt_d    = cnt_q + CW'(1);

  assign last_iter = (cnt_q == CW'(WIDTH - 1));

`ifdef MUL_EARLY_EXIT_EN
  // Once the multiplier has no set bits left, later iterations only add zero.
  assign finish = last_iter || (mplier_d == '0);
`else
  assign finish = last_iter;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            mcand_q  <= {{WIDTH{1'b0}}, src1_i};
            mplier_q <= src2_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= BUSY;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end
          done_q <= 1'b0;
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_d;
          if (finish) begin
            prod_q  <= acc_d;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stall must see an acceptable start in the same cycle so the PC freezes before the accepting edge.
  assign stall_o   = (state_q == BUSY) || (((state_q == IDLE) || (state_q == DONE)) && accept);
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = prod_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer (WIDTH=32) with an expected-product scoreboard queue.
module tb_mul_sequencer;

  localparam int W = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic [2:0]      alu;
  logic            flush;
  logic [W-1:0]    src1, src2;
  logic            stall, busy, done;
  logic [2*W-1:0]  product;

  int n_chk  = 0;
  int n_fail = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] prev;
  int nb;
  int nd;

  mul_sequencer #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .ALUCtrl_i (alu),
    .flush_i   (flush),
    .src1_i    (src1),
    .src2_i    (src2),
    .stall_o   (stall),
    .busy_o    (busy),
    .done_o    (done),
    .product_o (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done_o is seen, counting BUSY samples.
  task automatic wait_done(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 100 && done !== 1'b1; i++) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    check("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check(tag, product, e);
      prev = e;
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    src1 = a; src2 = b; alu = 3'b011; start = 1'b1;
    #1;
    check("stall_on_start", {63'd0, stall}, 64'd1);
    if (push) sb.push_back(64'(a) * 64'(b));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
  endtask

  task automatic watch_no_done(input int cycles, input string tag);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    check(tag, 64'(nd), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; alu = 3'b000; flush = 1'b0; src1 = '0; src2 = '0;
    prev = '0;
    #2;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_product", product, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 3 * 5: 32 BUSY cycles, then a single done pulse with stall low
    start_op(32'd3, 32'd5, 1'b1);
    wait_done(nb);
    check("mul3x5_busy_cycles", 64'(nb), 64'd32);
    pop_check("mul3x5_product");
    check("mul3x5_stall_in_done", {63'd0, stall}, 64'd0);
    check("mul3x5_busy_in_done", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("mul3x5_done_one_cycle", {63'd0, done}, 64'd0);

    // all-ones operands; start with other operands during BUSY must be ignored
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    src1 = 32'h1234; src2 = 32'h5678; start = 1'b1;
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
    end
    check("busy_stall_high", {63'd0, stall}, 64'd1);
    start = 1'b0;
    begin
      int nb2;
      wait_done(nb2);
      nb = nb + nb2;
    end
    check("ones_busy_cycles", 64'(nb), 64'd32);
    pop_check("ones_product");
    check("ones_product_const", product, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);

    // non-multiply ALU code: ignored
    alu = 3'b010; start = 1'b1; src1 = 32'd2; src2 = 32'd2;
    #1;
    check("alu010_stall", {63'd0, stall}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("alu010_busy", {63'd0, busy}, 64'd0);
      check("alu010_done", {63'd0, done}, 64'd0);
      check("alu010_product", product, prev);
    end
    start = 1'b0;

    // flush at BUSY cycle 10
    start_op(32'd3, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    check("flush_stall", {63'd0, stall}, 64'd0);
    check("flush_product_hold", product, prev);
    watch_no_done(40, "flush_no_done");
    check("flush_product_hold_late", product, prev);

    // reset at BUSY cycle 10: outputs clear without a clock edge
    start_op(32'd3, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_stall", {63'd0, stall}, 64'd0);
    check("midrst_product", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    prev = '0;
    watch_no_done(40, "midrst_no_done");

    // back-to-back: start held through DONE
    src1 = 32'd7; src2 = 32'd6; alu = 3'b011; start = 1'b1;
    #1;
    check("b2b_stall_start", {63'd0, stall}, 64'd1);
    sb.push_back(64'd42);
    @(negedge clk);
    check("b2b_busy1", {63'd0, busy}, 64'd1);
    wait_done(nb);
    check("b2b_busy_cycles1", 64'(nb), 64'd32);
    check("b2b_stall_in_done", {63'd0, stall}, 64'd1);
    sb.push_back(64'd42);
    pop_check("b2b_product1");
    @(negedge clk);
    start = 1'b0;
    check("b2b_reaccept_busy", {63'd0, busy}, 64'd1);
    check("b2b_reaccept_done", {63'd0, done}, 64'd0);
    wait_done(nb);
    check("b2b_busy_cycles2", 64'(nb), 64'd32);
    pop_check("b2b_product2");
    check("b2b_stall_done2", {63'd0, stall}, 64'd0);
    @(negedge clk);
    check("b2b_done_cleared", {63'd0, done}, 64'd0);

`ifdef MUL_EARLY_EXIT_EN
    start_op(32'd9, 32'd4, 1'b1);
    wait_done(nb);
    check("early_src2_4_cycles", 64'(nb), 64'd3);
    pop_check("early_src2_4_product");
    @(negedge clk);
    start_op(32'd9, 32'd0, 1'b1);
    wait_done(nb);
    check("early_src2_0_cycles", 64'(nb), 64'd1);
    pop_check("early_src2_0_product");
    @(negedge clk);
`else
    start_op(32'd9, 32'd4, 1'b1);
    wait_done(nb);
    check("full_src2_4_cycles", 64'(nb), 64'd32);
    pop_check("full_src2_4_product");
    @(negedge clk);
    start_op(32'd9, 32'd0, 1'b1);
    wait_done(nb);
    check("full_src2_0_cycles", 64'(nb), 64'd32);
    pop_check("full_src2_0_product");
    @(negedge clk);
`endif

    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
